// File: rtl/hcsr04_pkg.sv
// Shared register map, bit positions and ranger FSM encoding for the
// HC-SR04 AXI4-Lite ranging block.
package hcsr04_pkg;
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_ECHO   = 2'd2;
  localparam logic [1:0] REG_PERIOD = 2'd3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_CONT    = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_DONE,
    ST_HOLDOFF
  } ranger_state_t;
endpackage

// File: rtl/hcsr04_ranger.sv
// Ranging engine: echo synchronizer, trigger/measure FSM, width, timeout
// and repetition-period counters.
module hcsr04_ranger
  import hcsr04_pkg::*;
#(
  parameter int TRIG_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 3800000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        cont_i,
  input  logic [31:0] period_i,
  input  logic        echo_i,
  output logic        trig_o,
  output logic        busy_o,
  output logic        done_pulse_o,
  output logic        timeout_pulse_o,
  output logic [31:0] echo_cnt_o
);
  localparam logic [31:0] TRIG_LAST = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  ranger_state_t           state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    echo_dly_q, cont_dly_q, trig_q, flag_q, flag_d;
  logic [31:0]             trg_q, trg_d, tmo_q, tmo_d, cnt_q, cnt_d;
  logic [31:0]             per_q, per_d, echo_cnt_q, echo_cnt_d;
  logic                    echo_s, echo_rise, echo_fall, tmo_hit;

  assign echo_s    = sync_q[SYNC_STAGES-1];
  assign echo_rise = echo_s & ~echo_dly_q;
  assign echo_fall = ~echo_s & echo_dly_q;
  assign tmo_hit   = (tmo_q >= TMO_LAST);

  always_comb begin
    state_d         = state_q;
    trg_d           = trg_q;
    tmo_d           = tmo_q;
    cnt_d           = cnt_q;
    per_d           = per_q + 32'd1;
    flag_d          = flag_q;
    echo_cnt_d      = echo_cnt_q;
    done_pulse_o    = 1'b0;
    timeout_pulse_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        per_d = '0;
        if (start_i || (cont_i && !cont_dly_q)) state_d = ST_TRIG;
      end
      ST_TRIG: begin
        trg_d = trg_q + 32'd1;
        if (trg_q == TRIG_LAST) begin
          state_d = ST_WAIT_RISE;
          tmo_d   = '0;
        end
      end
      ST_WAIT_RISE: begin
        tmo_d = tmo_q + 32'd1;
        if (tmo_hit) begin
          state_d = ST_DONE;
          flag_d  = 1'b1;
        end else if (echo_rise) begin
          state_d = ST_MEASURE;
          cnt_d   = '0;
        end
      end
      ST_MEASURE: begin
        tmo_d = tmo_q + 32'd1;
        // Counting the delayed echo includes the rise cycle, so the result is the full high width.
        if (echo_dly_q) cnt_d = cnt_q + 32'd1;
        if (tmo_hit) begin
          state_d = ST_DONE;
          flag_d  = 1'b1;
        end else if (echo_fall) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (flag_q) begin
          timeout_pulse_o = 1'b1;
          echo_cnt_d      = '0;
        end else begin
          done_pulse_o = 1'b1;
          echo_cnt_d   = cnt_q;
        end
        state_d = cont_i ? ST_HOLDOFF : ST_IDLE;
      end
      ST_HOLDOFF: begin
        if (!cont_i) state_d = ST_IDLE;
        else if (({1'b0, per_q} + 33'd1) >= {1'b0, period_i}) state_d = ST_TRIG;
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_d == ST_TRIG) && (state_q != ST_TRIG)) begin
      trg_d  = '0;
      per_d  = '0;
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      sync_q     <= '0;
      echo_dly_q <= 1'b0;
      cont_dly_q <= 1'b0;
      trig_q     <= 1'b0;
      flag_q     <= 1'b0;
      trg_q      <= '0;
      tmo_q      <= '0;
      cnt_q      <= '0;
      per_q      <= '0;
      echo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], echo_i};
      echo_dly_q <= echo_s;
      cont_dly_q <= cont_i;
      trig_q     <= (state_d == ST_TRIG);
      flag_q     <= flag_d;
      trg_q      <= trg_d;
      tmo_q      <= tmo_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      echo_cnt_q <= echo_cnt_d;
    end
  end

  assign trig_o     = trig_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign echo_cnt_o = echo_cnt_q;
endmodule

// File: rtl/hcsr04_axil_ranger.sv
// AXI4-Lite register front end for the HC-SR04 ranger: CTRL, STATUS,
// ECHO_CNT and PERIOD, plus the level interrupt.
module hcsr04_axil_ranger
  import hcsr04_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int TRIG_CYCLES        = 1000,
  parameter int TIMEOUT_CYCLES     = 3800000,
  parameter int PERIOD_RST         = 6000000,
  parameter int SYNC_STAGES        = 2
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            trig_o,
  input  logic                            echo_i,
  output logic                            irq_o
);
  logic        awready_q, bvalid_q, arready_q, rvalid_q, irq_q;
  logic [31:0] rdata_q, rd_data, period_q, period_d, echo_cnt;
  logic        cont_q, cont_d, irqen_q, irqen_d, start_q, start_d;
  logic        done_q, done_d, tmo_q, tmo_d;
  logic        busy, done_pulse, timeout_pulse, wr_en, rd_en;
  logic [1:0]  wr_addr, rd_addr;
  logic        unused_ok;

  // Protection and byte-lane address bits carry no meaning for this block.
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_en   = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en   = arready_q & S_AXI_ARVALID;
  assign wr_addr = S_AXI_AWADDR[3:2];
  assign rd_addr = S_AXI_ARADDR[3:2];

  always_comb begin
    cont_d   = cont_q;
    irqen_d  = irqen_q;
    start_d  = 1'b0;
    period_d = period_q;
    done_d   = done_q;
    tmo_d    = tmo_q;
    if (wr_en && S_AXI_WSTRB[0]) begin
      case (wr_addr)
        REG_CTRL: begin
          start_d = S_AXI_WDATA[CTRL_START];
          cont_d  = S_AXI_WDATA[CTRL_CONT];
          irqen_d = S_AXI_WDATA[CTRL_IRQ_EN];
        end
        REG_STATUS: begin
          if (S_AXI_WDATA[STAT_DONE])    done_d = 1'b0;
          if (S_AXI_WDATA[STAT_TIMEOUT]) tmo_d  = 1'b0;
        end
        default: ;
      endcase
    end
    if (wr_en && (wr_addr == REG_PERIOD)) begin
      for (int b = 0; b < 4; b++) begin
        if (S_AXI_WSTRB[b]) period_d[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
      end
    end
    // A hardware event in the same cycle as a clear must not be lost.
    if (done_pulse)    done_d = 1'b1;
    if (timeout_pulse) tmo_d  = 1'b1;
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      REG_CTRL: begin
        rd_data[CTRL_CONT]   = cont_q;
        rd_data[CTRL_IRQ_EN] = irqen_q;
      end
      REG_STATUS: begin
        rd_data[STAT_BUSY]    = busy;
        rd_data[STAT_DONE]    = done_q;
        rd_data[STAT_TIMEOUT] = tmo_q;
      end
      REG_ECHO:   rd_data = echo_cnt;
      REG_PERIOD: rd_data = period_q;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      cont_q    <= 1'b0;
      irqen_q   <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      period_q  <= 32'(PERIOD_RST);
      irq_q     <= 1'b0;
    end else begin
      awready_q <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
      if (wr_en) bvalid_q <= 1'b1;
      else if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;
      arready_q <= S_AXI_ARVALID & ~rvalid_q & ~arready_q;
      if (rd_en) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
      cont_q   <= cont_d;
      irqen_q  <= irqen_d;
      start_q  <= start_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      period_q <= period_d;
      irq_q    <= irqen_q & (done_q | tmo_q);
    end
  end

  hcsr04_ranger #(
    .TRIG_CYCLES   (TRIG_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_ranger (
    .clk_i          (ACLK),
    .rst_ni         (ARESETN),
    .start_i        (start_q),
    .cont_i         (cont_q),
    .period_i       (period_q),
    .echo_i         (echo_i),
    .trig_o         (trig_o),
    .busy_o         (busy),
    .done_pulse_o   (done_pulse),
    .timeout_pulse_o(timeout_pulse),
    .echo_cnt_o     (echo_cnt)
  );

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = AXI_RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = AXI_RESP_OKAY;
  assign irq_o         = irq_q;
endmodule

// File: tb/tb_hcsr04_axil_ranger.sv
// Directed bench for hcsr04_axil_ranger: register access, single-shot,
// timeout, clear/set race, continuous mode, AXI handshakes and reset.
module tb_hcsr04_axil_ranger;
  localparam int PRST = 6000000;

  logic        ACLK = 1'b0, ARESETN = 1'b0;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID, trig_o, irq_o;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;
  logic        echo = 1'b0;
  bit          echo_en = 1'b0;

  int checks = 0, fails = 0;
  int cyc = 0, run_len = 0, last_w = 0, falls = 0, rises = 0;
  int rise_cyc [64];
  logic trig_prev = 1'b0;

  always #5 ACLK = ~ACLK;

  hcsr04_axil_ranger #(
    .TRIG_CYCLES(10), .TIMEOUT_CYCLES(200), .PERIOD_RST(PRST), .SYNC_STAGES(2)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(rready),
    .trig_o(trig_o), .echo_i(echo), .irq_o(irq_o)
  );

  // Trigger monitor: pulse widths and rising-edge cycle stamps.
  always @(negedge ACLK) begin
    cyc = cyc + 1;
    if (trig_o && !trig_prev) begin
      rise_cyc[rises % 64] = cyc;
      rises = rises + 1;
    end
    if (trig_o) run_len = run_len + 1;
    else begin
      if (trig_prev) begin
        last_w = run_len;
        falls  = falls + 1;
      end
      run_len = 0;
    end
    trig_prev = trig_o;
  end

  // Sensor model: echo goes high 20 cycles after trigger falls, for 50 cycles.
  always @(negedge trig_o) begin
    if (echo_en && ARESETN) begin
      repeat (20) @(negedge ACLK);
      echo = 1'b1;
      repeat (50) @(negedge ACLK);
      echo = 1'b0;
    end
  end

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge ACLK);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!AWREADY && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) begin checks++; fails++; $display("FAIL axi_write_aw addr=%h no AWREADY", a); end
    @(posedge ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!BVALID && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) begin checks++; fails++; $display("FAIL axi_write_b addr=%h no BVALID", a); end
    @(posedge ACLK); #1;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    @(negedge ACLK);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!ARREADY && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) begin checks++; fails++; $display("FAIL axi_read_ar addr=%h no ARREADY", a); end
    @(posedge ACLK); #1;
    arvalid = 1'b0;
    n = 0;
    while (!RVALID && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) begin checks++; fails++; $display("FAIL axi_read_r addr=%h no RVALID", a); end
    d = RDATA;
    @(posedge ACLK); #1;
  endtask

  task automatic wait_falls(input int target, input int bound);
    int n = 0;
    while (falls < target && n < bound) begin @(negedge ACLK); n++; end
    if (falls < target) begin checks++; fails++; $display("FAIL wait_trig_fall falls=%0d need=%0d", falls, target); end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #1;
    checks++;
    if ({trig_o, irq_o, AWREADY, BVALID, ARREADY, RVALID} !== 6'b0) begin
      fails++; $display("FAIL reset_outputs got=%b want=000000", {trig_o, irq_o, AWREADY, BVALID, ARREADY, RVALID});
    end
    repeat (3) @(posedge ACLK);
    @(negedge ACLK); ARESETN = 1'b1;
    axi_read(4'h0, d); checks++;
    if (d !== 32'h0) begin fails++; $display("FAIL reset_ctrl got=%h want=0", d); end
    axi_read(4'h4, d); checks++;
    if (d !== 32'h0) begin fails++; $display("FAIL reset_status got=%h want=0", d); end
    axi_read(4'h8, d); checks++;
    if (d !== 32'h0) begin fails++; $display("FAIL reset_echo got=%h want=0", d); end
    axi_read(4'hC, d); checks++;
    if (d !== 32'(PRST)) begin fails++; $display("FAIL reset_period got=%h want=%h", d, 32'(PRST)); end
  endtask

  task automatic test_single_shot();
    logic [31:0] d;
    int f0, n;
    echo_en = 1'b1;
    f0 = falls;
    axi_write(4'h0, 32'h5, 4'hF);
    wait_falls(f0 + 1, 100);
    checks++;
    if (last_w !== 10) begin fails++; $display("FAIL trig_width got=%0d want=10", last_w); end
    repeat (25) @(negedge ACLK);
    axi_read(4'h4, d); checks++;
    if (d !== 32'h1) begin fails++; $display("FAIL busy_in_measure got=%h want=1", d); end
    n = 0;
    do begin axi_read(4'h4, d); n++; end while (!d[1] && n < 40);
    checks++;
    if (d !== 32'h2) begin fails++; $display("FAIL single_status got=%h want=2", d); end
    axi_read(4'h8, d); checks++;
    if (d !== 32'd50) begin fails++; $display("FAIL single_echo got=%0d want=50", d); end
    @(negedge ACLK); checks++;
    if (irq_o !== 1'b1) begin fails++; $display("FAIL irq_set got=%b want=1", irq_o); end
    axi_write(4'h4, 32'h2, 4'hF);
    axi_write(4'h0, 32'h0, 4'hF);
    @(negedge ACLK); checks++;
    if (irq_o !== 1'b0) begin fails++; $display("FAIL irq_clear got=%b want=0", irq_o); end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    int f0, n;
    echo_en = 1'b0;
    f0 = falls;
    axi_write(4'h0, 32'h1, 4'hF);
    wait_falls(f0 + 1, 100);
    repeat (170) @(negedge ACLK);
    axi_read(4'h4, d); checks++;
    if (d !== 32'h1) begin fails++; $display("FAIL pre_timeout_status got=%h want=1", d); end
    n = 0;
    do begin axi_read(4'h4, d); n++; end while (!d[2] && n < 40);
    checks++;
    if (d !== 32'h4) begin fails++; $display("FAIL timeout_status got=%h want=4", d); end
    axi_read(4'h8, d); checks++;
    if (d !== 32'h0) begin fails++; $display("FAIL timeout_echo got=%h want=0", d); end
    checks++;
    if (irq_o !== 1'b0) begin fails++; $display("FAIL timeout_irq_masked got=%b want=0", irq_o); end
    axi_write(4'h4, 32'h4, 4'hF);
    axi_read(4'h4, d); checks++;
    if (d !== 32'h0) begin fails++; $display("FAIL timeout_w1c got=%h want=0", d); end
  endtask

  task automatic test_done_race();
    logic [31:0] d;
    int f0, n;
    echo_en = 1'b0;
    f0 = falls;
    axi_write(4'h0, 32'h1, 4'hF);
    wait_falls(f0 + 1, 100);
    repeat (5) @(negedge ACLK);
    echo = 1'b1;
    repeat (10) @(negedge ACLK);
    echo = 1'b0;
    repeat (2) @(negedge ACLK);
    awaddr = 4'h4; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge ACLK); checks++;
    if ({AWREADY, dut.u_ranger.done_pulse_o} !== 2'b11) begin
      fails++; $display("FAIL race_align awready_done=%b want=11", {AWREADY, dut.u_ranger.done_pulse_o});
    end
    @(posedge ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!BVALID && n < 20) begin @(negedge ACLK); n++; end
    @(posedge ACLK); #1;
    axi_read(4'h4, d); checks++;
    if (d !== 32'h2) begin fails++; $display("FAIL race_set_wins got=%h want=2", d); end
    axi_read(4'h8, d); checks++;
    if (d !== 32'd10) begin fails++; $display("FAIL race_echo got=%0d want=10", d); end
    axi_write(4'h4, 32'h2, 4'hF);
  endtask

  task automatic test_continuous();
    logic [31:0] d;
    int r0, r1, f0, n;
    echo_en = 1'b1;
    axi_write(4'hC, 32'd300, 4'hF);
    r0 = rises;
    axi_write(4'h0, 32'h2, 4'hF);
    n = 0;
    while (rises < r0 + 3 && n < 1200) begin @(negedge ACLK); n++; end
    checks++;
    if (rises < r0 + 3) begin fails++; $display("FAIL cont_rises got=%0d want=%0d", rises - r0, 3); end
    checks++;
    if (rise_cyc[(r0 + 1) % 64] - rise_cyc[r0 % 64] !== 300) begin
      fails++; $display("FAIL cont_period1 got=%0d want=300", rise_cyc[(r0 + 1) % 64] - rise_cyc[r0 % 64]);
    end
    checks++;
    if (rise_cyc[(r0 + 2) % 64] - rise_cyc[(r0 + 1) % 64] !== 300) begin
      fails++; $display("FAIL cont_period2 got=%0d want=300", rise_cyc[(r0 + 2) % 64] - rise_cyc[(r0 + 1) % 64]);
    end
    f0 = falls;
    wait_falls(f0 + 1, 100);
    repeat (28) @(negedge ACLK);
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h4, 32'h2, 4'hF);
    axi_read(4'h4, d); checks++;
    if (d !== 32'h1) begin fails++; $display("FAIL cont_stop_busy got=%h want=1", d); end
    r1 = rises;
    repeat (400) @(negedge ACLK);
    checks++;
    if (rises !== r1) begin fails++; $display("FAIL cont_no_retrig got=%0d want=0", rises - r1); end
    axi_read(4'h4, d); checks++;
    if (d !== 32'h2) begin fails++; $display("FAIL cont_final_status got=%h want=2", d); end
    axi_read(4'h8, d); checks++;
    if (d !== 32'd50) begin fails++; $display("FAIL cont_echo got=%0d want=50", d); end
  endtask

  task automatic test_axi_stress();
    logic [31:0] d;
    logic ok, acc;
    int n;
    @(negedge ACLK);
    awaddr = 4'hC; wdata = 32'h100; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!AWREADY && n < 20) begin @(negedge ACLK); n++; end
    @(posedge ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    ok = 1'b1;
    repeat (5) begin @(negedge ACLK); if (!BVALID || BRESP !== 2'b00) ok = 1'b0; end
    checks++;
    if (ok !== 1'b1) begin fails++; $display("FAIL bvalid_hold got=%b want=1", ok); end
    wdata = 32'h200; awvalid = 1'b1; wvalid = 1'b1;
    acc = 1'b0;
    repeat (3) begin @(negedge ACLK); if (AWREADY) acc = 1'b1; end
    checks++;
    if (acc !== 1'b0) begin fails++; $display("FAIL aw_blocked_by_b got=%b want=0", acc); end
    bready = 1'b1;
    @(posedge ACLK); #1;
    checks++;
    if (BVALID !== 1'b0) begin fails++; $display("FAIL b_handshake got=%b want=0", BVALID); end
    n = 0;
    while (!AWREADY && n < 20) begin @(negedge ACLK); n++; end
    @(posedge ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!BVALID && n < 20) begin @(negedge ACLK); n++; end
    @(posedge ACLK); #1;
    axi_read(4'hC, d); checks++;
    if (d !== 32'h200) begin fails++; $display("FAIL second_write got=%h want=200", d); end

    @(negedge ACLK);
    awaddr = 4'hC; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
    acc = 1'b0;
    repeat (3) begin @(negedge ACLK); if (AWREADY) acc = 1'b1; end
    checks++;
    if (acc !== 1'b0) begin fails++; $display("FAIL aw_waits_w got=%b want=0", acc); end
    wvalid = 1'b1;
    n = 0;
    while (!AWREADY && n < 20) begin @(negedge ACLK); n++; end
    @(posedge ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!BVALID && n < 20) begin @(negedge ACLK); n++; end
    @(posedge ACLK); #1;
    axi_read(4'hC, d); checks++;
    if (d !== 32'h12345678) begin fails++; $display("FAIL late_w_write got=%h want=12345678", d); end
    axi_write(4'hC, 32'hFFFFFFFF, 4'h1);
    axi_read(4'hC, d); checks++;
    if (d !== 32'h123456FF) begin fails++; $display("FAIL wstrb_byte0 got=%h want=123456ff", d); end
  endtask

  task automatic test_reset_mid_trig();
    logic [31:0] d;
    int n;
    echo_en = 1'b0;
    axi_write(4'h0, 32'h1, 4'hF);
    n = 0;
    while (!trig_o && n < 20) begin @(negedge ACLK); n++; end
    checks++;
    if (trig_o !== 1'b1) begin fails++; $display("FAIL trig_before_reset got=%b want=1", trig_o); end
    repeat (3) @(negedge ACLK);
    #2 ARESETN = 1'b0;
    #1 checks++;
    if (trig_o !== 1'b0) begin fails++; $display("FAIL trig_async_clear got=%b want=0", trig_o); end
    repeat (3) @(posedge ACLK);
    @(negedge ACLK); ARESETN = 1'b1;
    axi_read(4'hC, d); checks++;
    if (d !== 32'(PRST)) begin fails++; $display("FAIL post_reset_period got=%h want=%h", d, 32'(PRST)); end
    axi_read(4'h4, d); checks++;
    if (d !== 32'h0) begin fails++; $display("FAIL post_reset_status got=%h want=0", d); end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_timeout();
    test_done_race();
    test_continuous();
    test_axi_stress();
    test_reset_mid_trig();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
